rx_ltssm_substate_sequencer: RTL and testbench

//  Parametrised RX-side LTSSM substate sequencer with per-lane ordered-set counters and an internal timeout timer.

---
 rtl/rx_ltssm_pkg.sv | 59 +++++
 rtl/rx_ltssm_substate_sequencer_if.sv | 43 ++++
 rtl/rx_lane_os_counter.sv | 36 +++
 rtl/rx_ltssm_substate_sequencer.sv | 161 ++++++++++++++++
 tb/tb_rx_ltssm_substate_sequencer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/rx_ltssm_pkg.sv
// ----------------------------------------------------------------------------
// rx_ltssm_pkg
//   Shared definitions for the RX LTSSM substate sequencer:
//   - substate code constants (4-bit codes used on req_substate / exit_to)
//   - sequencer FSM state encoding
//   - lookupReq(): per-substate target ordered-set count and timeout (ticks)
// ----------------------------------------------------------------------------
package rx_ltssm_pkg;

    typedef enum logic [3:0] {
        SUB_DETECT_QUIET   = 4'd0,
        SUB_DETECT_ACTIVE  = 4'd1,
        SUB_POLLING_ACTIVE = 4'd2,
        SUB_POLLING_CFG    = 4'd3,
        SUB_CFG_LW_START   = 4'd4,
        SUB_CFG_LW_ACCEPT  = 4'd5,
        SUB_CFG_LN_WAIT    = 4'd6,
        SUB_CFG_LN_ACCEPT  = 4'd7,
        SUB_CFG_COMPLETE   = 4'd8,
        SUB_CFG_IDLE       = 4'd9
    } substate_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_SUCCESS,
        S_FAIL
    } state_e;

    // Table entry: known=0 marks an unsupported code (10..15).
    typedef struct packed {
        logic       known;
        logic [7:0] target;
        logic [7:0] timeout;
    } req_entry_t;

    // Detect and Polling substates run with the descrambler bypassed.
    localparam logic [3:0] LAST_DESCRAMBLE_OFF = SUB_POLLING_CFG;

    function automatic req_entry_t lookupReq(input logic [3:0] code);
        req_entry_t e;
        e = '{known: 1'b1, target: 8'd0, timeout: 8'd0};
        case (code)
            SUB_DETECT_QUIET:   begin e.target = 8'd0; e.timeout = 8'd12; end
            SUB_DETECT_ACTIVE:  begin e.target = 8'd0; e.timeout = 8'd0;  end
            SUB_POLLING_ACTIVE: begin e.target = 8'd8; e.timeout = 8'd24; end
            SUB_POLLING_CFG:    begin e.target = 8'd8; e.timeout = 8'd48; end
            SUB_CFG_LW_START,
            SUB_CFG_LW_ACCEPT,
            SUB_CFG_LN_ACCEPT:  begin e.target = 8'd2; e.timeout = 8'd24; end
            SUB_CFG_LN_WAIT:    begin e.target = 8'd2; e.timeout = 8'd2;  end
            SUB_CFG_COMPLETE:   begin e.target = 8'd8; e.timeout = 8'd24; end
            SUB_CFG_IDLE:       begin e.target = 8'd8; e.timeout = 8'd2;  end
            default:            e.known = 1'b0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/rx_ltssm_substate_sequencer_if.sv
// ----------------------------------------------------------------------------
// rx_ltssm_substate_sequencer_if
//   Bundle between the main LTSSM / lane checkers (master) and the substate
//   sequencer (slave).
//   master drives: req_valid, req_substate, num_lanes, lane_os_match,
//                  rx_elec_idle, force_detect, tick
//   slave drives:  busy, finish, exit_success, exit_to, lane_chk_reset,
//                  disable_descrambler
// ----------------------------------------------------------------------------
interface rx_ltssm_substate_sequencer_if #(
    parameter int MAXLANES = 16
);
    localparam int NLW = $clog2(MAXLANES) + 1;

    logic                req_valid;
    logic [3:0]          req_substate;
    logic [NLW-1:0]      num_lanes;
    logic [MAXLANES-1:0] lane_os_match;
    logic                rx_elec_idle;
    logic                force_detect;
    logic                tick;

    logic                busy;
    logic                finish;
    logic                exit_success;
    logic [3:0]          exit_to;
    logic [MAXLANES-1:0] lane_chk_reset;
    logic                disable_descrambler;

    modport master (
        output req_valid, req_substate, num_lanes, lane_os_match,
               rx_elec_idle, force_detect, tick,
        input  busy, finish, exit_success, exit_to, lane_chk_reset,
               disable_descrambler
    );

    modport slave (
        input  req_valid, req_substate, num_lanes, lane_os_match,
               rx_elec_idle, force_detect, tick,
        output busy, finish, exit_success, exit_to, lane_chk_reset,
               disable_descrambler
    );
endinterface

// File: rtl/rx_lane_os_counter.sv
// ----------------------------------------------------------------------------
// rx_lane_os_counter
//   Per-lane saturating ordered-set counter.
//   clk, reset : clock, synchronous active-high reset
//   clear      : synchronous clear (held while the sequencer is idle)
//   inc        : count one matching ordered set this cycle
//   target     : saturation value / goal
//   reached    : count >= target, including this cycle's increment, so the
//                sequencer can finish one cycle after the last ordered set
// ----------------------------------------------------------------------------
module rx_lane_os_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    input  logic [CNT_W-1:0] target,
    output logic             reached
);
    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (inc && (cnt < target)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Below target, cnt+1 cannot wrap; at or above target the first term wins.
    assign reached = (cnt >= target) || (inc && ((cnt + CNT_W'(1)) >= target));

endmodule

// File: rtl/rx_ltssm_substate_sequencer.sv
// ----------------------------------------------------------------------------
// rx_ltssm_substate_sequencer
//   Runs one LTSSM substate request: counts matching ordered sets on every
//   active lane against a per-substate target, times out on tick, and ends
//   with a one-cycle finish pulse carrying success/next-substate or
//   fail/detectQuiet.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : slave side of rx_ltssm_substate_sequencer_if (request, lane
//           matches, idle/abort/tick inputs; status and lane-control outputs)
// ----------------------------------------------------------------------------
module rx_ltssm_substate_sequencer
    import rx_ltssm_pkg::*;
#(
    parameter int MAXLANES = 16,
    parameter int CNT_W    = 4,
    parameter int TMR_W    = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    rx_ltssm_substate_sequencer_if.slave  bus
);
    localparam int NLW = $clog2(MAXLANES) + 1;

    state_e              state;
    logic [3:0]          substate;
    logic [CNT_W-1:0]    target;
    logic [TMR_W-1:0]    timeout;
    logic [TMR_W-1:0]    timer;
    logic [MAXLANES-1:0] laneMask;

    logic                busyReg;
    logic                finishReg;
    logic                exitSuccessReg;
    logic [3:0]          exitToReg;
    logic [MAXLANES-1:0] laneChkResetReg;
    logic                disableDescReg;

    req_entry_t          reqEntry;
    logic [MAXLANES-1:0] reqMask;
    logic                reqWidthOk;
    logic [MAXLANES-1:0] laneInc;
    logic [MAXLANES-1:0] laneReached;
    logic [TMR_W-1:0]    timerNext;
    logic                expired;
    logic                successNow;

    // Request decode: table lookup plus lane-width legality (non-zero power
    // of two not above MAXLANES) and the matching low-bits lane mask.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        reqEntry   = lookupReq(bus.req_substate);
        reqMask    = '0;
        for (int i = 0; i < MAXLANES; i++) begin
            reqMask[i] = (i < int'(bus.num_lanes));
        end
        reqWidthOk = (bus.num_lanes != '0)
                  && ((bus.num_lanes & (bus.num_lanes - NLW'(1))) == '0)
                  && (int'(bus.num_lanes) <= MAXLANES);
    end

    for (genvar g = 0; g < MAXLANES; g++) begin : gLane
        assign laneInc[g] = (state == S_COUNT) && bus.lane_os_match[g] && laneMask[g];

        rx_lane_os_counter #(
            .CNT_W (CNT_W)
        ) uCnt (
            .clk     (clk),
            .reset   (reset),
            .clear   (state == S_IDLE),
            .inc     (laneInc[g]),
            .target  (target),
            .reached (laneReached[g])
        );
    end

    // Completion conditions look ahead by one tick/match so the finish pulse
    // lands exactly one cycle after the enabling event. timer==timeout alone
    // covers a zero timeout in the first COUNT cycle.
    always_comb begin
        timerNext  = timer + TMR_W'(bus.tick);
        expired    = (timer == timeout) || (timerNext == timeout);
        successNow = (&(laneReached | ~laneMask))
                  && ((substate != SUB_DETECT_QUIET) || bus.rx_elec_idle || expired);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            substate        <= '0;
            target          <= '0;
            timeout         <= '0;
            timer           <= '0;
            laneMask        <= '0;
            busyReg         <= 1'b0;
            finishReg       <= 1'b0;
            exitSuccessReg  <= 1'b0;
            exitToReg       <= '0;
            laneChkResetReg <= '1;
            disableDescReg  <= 1'b0;
        end else begin
            finishReg <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        substate <= bus.req_substate;
                        target   <= CNT_W'(reqEntry.target);
                        timeout  <= TMR_W'(reqEntry.timeout);
                        laneMask <= reqMask;
                        timer    <= '0;
                        busyReg  <= 1'b1;
                        if (reqEntry.known && reqWidthOk) begin
                            state           <= S_COUNT;
                            laneChkResetReg <= ~reqMask;
                            disableDescReg  <= (bus.req_substate <= LAST_DESCRAMBLE_OFF);
                        end else begin
                            state          <= S_FAIL;
                            finishReg      <= 1'b1;
                            exitSuccessReg <= 1'b0;
                            exitToReg      <= '0;
                        end
                    end
                end

                S_COUNT: begin
                    timer <= timerNext;
                    if (bus.force_detect || successNow || expired) begin
                        finishReg       <= 1'b1;
                        laneChkResetReg <= '1;
                        disableDescReg  <= 1'b0;
                        // force_detect outranks success, success outranks expiry.
                        if (!bus.force_detect && successNow) begin
                            state          <= S_SUCCESS;
                            exitSuccessReg <= 1'b1;
                            exitToReg      <= substate + 4'd1;
                        end else begin
                            state          <= S_FAIL;
                            exitSuccessReg <= 1'b0;
                            exitToReg      <= '0;
                        end
                    end
                end

                default: begin
                    // SUCCESS / FAIL: the finish cycle itself.
                    state   <= S_IDLE;
                    busyReg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy                = busyReg;
    assign bus.finish              = finishReg;
    assign bus.exit_success        = exitSuccessReg;
    assign bus.exit_to             = exitToReg;
    assign bus.lane_chk_reset      = laneChkResetReg;
    assign bus.disable_descrambler = disableDescReg;

endmodule

// File: tb/tb_rx_ltssm_substate_sequencer.sv
// ----------------------------------------------------------------------------
// tb_rx_ltssm_substate_sequencer
//   Cycle-by-cycle vector table for rx_ltssm_substate_sequencer (MAXLANES=16).
//   Each row: inputs held for one cycle, then outputs expected right after
//   the rising edge that closes that cycle. Hand-written sequences follow for
//   the detectQuiet timeout and reset in the middle of a request.
// ----------------------------------------------------------------------------
module tb_rx_ltssm_substate_sequencer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    rx_ltssm_substate_sequencer_if #(.MAXLANES(16)) bus ();

    rx_ltssm_substate_sequencer #(
        .MAXLANES (16),
        .CNT_W    (4),
        .TMR_W    (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        reqValid;
        logic [3:0]  sub;
        logic [4:0]  nl;
        logic [15:0] match;
        logic        elecIdle;
        logic        forceDet;
        logic        tick;
        logic        eBusy;
        logic        eFinish;
        logic        eSucc;
        logic [3:0]  eTo;
        logic [15:0] eLcr;
        logic        eDd;
    } vec_t;

    vec_t vecs[$];
    int   applied     = 0;
    int   miscompares = 0;

    function automatic void add(input logic rv, input logic [3:0] sub, input logic [4:0] nl,
                                input logic [15:0] match, input logic ei, input logic fd,
                                input logic tk, input logic eb, input logic ef, input logic es,
                                input logic [3:0] eto, input logic [15:0] elcr, input logic edd);
        vec_t v;
        v.reqValid = rv;  v.sub = sub;     v.nl = nl;     v.match = match;
        v.elecIdle = ei;  v.forceDet = fd; v.tick = tk;
        v.eBusy = eb;     v.eFinish = ef;  v.eSucc = es;  v.eTo = eto;
        v.eLcr = elcr;    v.eDd = edd;
        vecs.push_back(v);
    endfunction

    function automatic void addIdle(input logic eb, input logic ef, input logic es,
                                    input logic [3:0] eto, input logic [15:0] elcr, input logic edd);
        add(1'b0, 4'd0, 5'd0, 16'h0, 1'b0, 1'b0, 1'b0, eb, ef, es, eto, elcr, edd);
    endfunction

    function automatic logic [31:0] obs();
        return {8'd0, bus.busy, bus.finish, bus.exit_success, bus.exit_to,
                bus.lane_chk_reset, bus.disable_descrambler};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic driveIdle();
        bus.req_valid     = 1'b0;
        bus.req_substate  = 4'd0;
        bus.num_lanes     = 5'd0;
        bus.lane_os_match = 16'h0;
        bus.rx_elec_idle  = 1'b0;
        bus.force_detect  = 1'b0;
        bus.tick          = 1'b0;
    endtask

    task automatic applyVec(input vec_t v, input int idx);
        bus.req_valid     = v.reqValid;
        bus.req_substate  = v.sub;
        bus.num_lanes     = v.nl;
        bus.lane_os_match = v.match;
        bus.rx_elec_idle  = v.elecIdle;
        bus.force_detect  = v.forceDet;
        bus.tick          = v.tick;
        @(posedge clk);
        #1;
        check($sformatf("vec%0d", idx), obs(),
              {8'd0, v.eBusy, v.eFinish, v.eSucc, v.eTo, v.eLcr, v.eDd});
    endtask

    task automatic buildTable();
        // pollingActive, 4 lanes: 8 OS per active lane, lane 4 inactive.
        add(1, 4'd2, 5'd4, 16'h0, 0, 0, 0,   1, 0, 0, 4'd0, 16'hFFF0, 1);
        for (int i = 0; i < 7; i++)
            add(0, 4'd0, 5'd0, 16'h001F, 0, 0, 0, 1, 0, 0, 4'd0, 16'hFFF0, 1);
        add(0, 4'd0, 5'd0, 16'h000F, 0, 0, 0, 1, 1, 1, 4'd3, 16'hFFFF, 0);
        addIdle(0, 0, 1, 4'd3, 16'hFFFF, 0);

        // pollingCfg, 8 lanes: request while busy ignored, force_detect aborts.
        add(1, 4'd3, 5'd8, 16'h0, 0, 0, 0,    1, 0, 1, 4'd3, 16'hFF00, 1);
        add(1, 4'd1, 5'd1, 16'h00FF, 0, 0, 0, 1, 0, 1, 4'd3, 16'hFF00, 1);
        add(0, 4'd0, 5'd0, 16'h00FF, 0, 0, 1, 1, 0, 1, 4'd3, 16'hFF00, 1);
        add(0, 4'd0, 5'd0, 16'h0, 0, 1, 0,    1, 1, 0, 4'd0, 16'hFFFF, 0);
        addIdle(0, 0, 0, 4'd0, 16'hFFFF, 0);

        // detectQuiet ends on rx_elec_idle in cycle 3; detectActive in 2 cycles.
        add(1, 4'd0, 5'd1, 16'h0, 0, 0, 0,    1, 0, 0, 4'd0, 16'hFFFE, 1);
        add(0, 4'd0, 5'd0, 16'h0, 0, 0, 1,    1, 0, 0, 4'd0, 16'hFFFE, 1);
        addIdle(1, 0, 0, 4'd0, 16'hFFFE, 1);
        add(0, 4'd0, 5'd0, 16'h0, 1, 0, 0,    1, 1, 1, 4'd1, 16'hFFFF, 0);
        addIdle(0, 0, 1, 4'd1, 16'hFFFF, 0);
        add(1, 4'd1, 5'd1, 16'h0, 0, 0, 0,    1, 0, 1, 4'd1, 16'hFFFE, 1);
        addIdle(1, 1, 1, 4'd2, 16'hFFFF, 0);
        addIdle(0, 0, 1, 4'd2, 16'hFFFF, 0);

        // cfgLnWait, 2 lanes: lane 1 silent, 2nd tick expires.
        add(1, 4'd6, 5'd2, 16'h0, 0, 0, 0,    1, 0, 1, 4'd2, 16'hFFFC, 0);
        add(0, 4'd0, 5'd0, 16'h0001, 0, 0, 1, 1, 0, 1, 4'd2, 16'hFFFC, 0);
        add(0, 4'd0, 5'd0, 16'h0001, 0, 0, 0, 1, 0, 1, 4'd2, 16'hFFFC, 0);
        add(0, 4'd0, 5'd0, 16'h0, 0, 0, 1,    1, 1, 0, 4'd0, 16'hFFFF, 0);
        addIdle(0, 0, 0, 4'd0, 16'hFFFF, 0);

        // cfgIdle, all 16 lanes: last count and expiry in the same cycle.
        add(1, 4'd9, 5'd16, 16'h0, 0, 0, 0,   1, 0, 0, 4'd0, 16'h0000, 0);
        add(0, 4'd0, 5'd0, 16'hFFFF, 0, 0, 1, 1, 0, 0, 4'd0, 16'h0000, 0);
        for (int i = 0; i < 6; i++)
            add(0, 4'd0, 5'd0, 16'hFFFF, 0, 0, 0, 1, 0, 0, 4'd0, 16'h0000, 0);
        add(0, 4'd0, 5'd0, 16'hFFFF, 0, 0, 1, 1, 1, 1, 4'd10, 16'hFFFF, 0);
        addIdle(0, 0, 1, 4'd10, 16'hFFFF, 0);

        // Illegal width 3 fails directly.
        add(1, 4'd2, 5'd3, 16'h0, 0, 0, 0,    1, 1, 0, 4'd0, 16'hFFFF, 0);
        addIdle(0, 0, 0, 4'd0, 16'hFFFF, 0);

        // detectActive again, then unsupported code 12 fails directly.
        add(1, 4'd1, 5'd1, 16'h0, 0, 0, 0,    1, 0, 0, 4'd0, 16'hFFFE, 1);
        addIdle(1, 1, 1, 4'd2, 16'hFFFF, 0);
        addIdle(0, 0, 1, 4'd2, 16'hFFFF, 0);
        add(1, 4'd12, 5'd1, 16'h0, 0, 0, 0,   1, 1, 0, 4'd0, 16'hFFFF, 0);
        addIdle(0, 0, 0, 4'd0, 16'hFFFF, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        logic saw;

        reset = 1'b1;
        driveIdle();
        buildTable();
        repeat (2) @(posedge clk);
        #1;
        check("reset state", obs(), {8'd0, 1'b0, 1'b0, 1'b0, 4'd0, 16'hFFFF, 1'b0});
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyVec(vecs[i], i);
        end

        // detectQuiet with no electrical idle: succeeds on timeout after 12 ticks.
        bus.req_valid    = 1'b1;
        bus.req_substate = 4'd0;
        bus.num_lanes    = 5'd2;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.tick      = 1'b1;
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.finish) break;
        end
        bus.tick = 1'b0;
        check("dq expiry latency", n, 32'd12);
        check("dq expiry exit", {27'd0, bus.exit_success, bus.exit_to}, {27'd0, 1'b1, 4'd1});
        @(posedge clk);
        #1;

        // Reset in the middle of COUNT: back to idle, no finish afterwards.
        bus.req_valid    = 1'b1;
        bus.req_substate = 4'd3;
        bus.num_lanes    = 5'd4;
        @(posedge clk);
        #1;
        driveIdle();
        bus.lane_os_match = 16'h000F;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset mid-count", obs(), {8'd0, 1'b0, 1'b0, 1'b0, 4'd0, 16'hFFFF, 1'b0});
        reset = 1'b0;
        bus.lane_os_match = 16'h0;
        saw = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            saw = saw | bus.finish | bus.busy;
        end
        check("quiet after reset", {31'd0, saw}, 32'd0);

        // Sequencer still accepts a request after the reset.
        bus.req_valid    = 1'b1;
        bus.req_substate = 4'd1;
        bus.num_lanes    = 5'd1;
        @(posedge clk);
        #1;
        driveIdle();
        @(posedge clk);
        #1;
        check("post-reset request", {26'd0, bus.finish, bus.exit_success, bus.exit_to},
              {26'd0, 1'b1, 1'b1, 4'd2});

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
